// File: rtl/shift_add_mult.sv
// Purpose : sequential shift-and-add multiplier, signed (two's complement) or unsigned operands.
// Latency : SIZE edges from accepting start to done (fewer with SHIFT_ADD_MULT_EARLY_TERM_EN).
// Backpr. : none; start is accepted only while idle and is ignored while busy=1.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-high
//   start     - begin a multiply (accepted only when idle)
//   signed_op - 1: two's-complement operands, 0: unsigned; sampled with start
//   a, b      - multiplicand / multiplier (SIZE bits); sampled with start
//   prod      - registered 2*SIZE-bit product, held until the next result
//   busy      - high while a multiply is in progress
//   done      - one-cycle pulse when prod is written
//
// Optional macro SHIFT_ADD_MULT_EARLY_TERM_EN: finish as soon as the
// remaining multiplier bits are all zero.
module shift_add_mult #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_op,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] prod,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]        state;
  logic [2*SIZE-1:0] aReg;
  logic [2*SIZE-1:0] acc;
  logic [2*SIZE-1:0] accNext;
  logic [SIZE-1:0]   bReg;
  logic [SIZE-1:0]   bNext;
  logic [SIZE-1:0]   aMag;
  logic [SIZE-1:0]   bMag;
  logic [CW-1:0]     count;
  logic              sign;
  logic              lastIter;

  // Magnitudes as unsigned SIZE-bit values; the most negative operand
  // negates to itself, which read unsigned is exactly 2^(SIZE-1).
  assign aMag = (signed_op && a[SIZE-1]) ? -a : a;
  assign bMag = (signed_op && b[SIZE-1]) ? -b : b;

  assign accNext = bReg[0] ? (acc + aReg) : acc;
  assign bNext   = bReg >> 1;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  // Once the shifted multiplier is zero no further partial products remain.
  assign lastIter = (count == LAST) || (bNext == '0);
`else
  assign lastIter = (count == LAST);
`endif

  assign busy = (state == CALC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      aReg  <= '0;
      bReg  <= '0;
      acc   <= '0;
      count <= '0;
      sign  <= 1'b0;
      prod  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= signed_op & (a[SIZE-1] ^ b[SIZE-1]);
            aReg  <= {{SIZE{1'b0}}, aMag};
            bReg  <= bMag;
            acc   <= '0;
            count <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= accNext;
          aReg  <= aReg << 1;
          bReg  <= bNext;
          count <= count + CW'(1);
          if (lastIter) begin
            // Use accNext so the final iteration's add lands in prod on this edge.
            prod  <= sign ? -accNext : accNext;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult (SIZE=32): directed corner cases plus random
// operands, compared with a plain-arithmetic product and latency model.
// Honours SHIFT_ADD_MULT_EARLY_TERM_EN for expected latency.
module tb_shift_add_mult;

  localparam int SIZE = 32;
  localparam int LIM  = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              signed_op;
  logic [SIZE-1:0]   a;
  logic [SIZE-1:0]   b;
  logic [2*SIZE-1:0] prod;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  shift_add_mult #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .prod      (prod),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference product from ordinary 64-bit arithmetic.
  function automatic logic [63:0] refProd(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    logic [63:0] ux;
    logic [63:0] uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
  endfunction

  // Expected edges from acceptance to done.
  function automatic int refLat(input logic s, input logic [31:0] y);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    logic [31:0] mag;
    mag = (s && y[31]) ? (~y + 32'd1) : y;
    for (int i = 31; i >= 0; i--)
      if (mag[i]) return i + 1;
    return 1;
`else
    return SIZE;
`endif
  endfunction

  // Present operands with start and let one rising edge accept them.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    signed_op = s;
    a         = x;
    b         = y;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input logic [63:0] expProd, input int expLat, input int pre);
    int lat;
    lat = pre;
    while (!done && lat < LIM) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkEq({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkEq({tag, "_prod"}, prod, expProd);
  endtask

  // Full operation plus the cycle after done: pulse ends, prod held.
  task automatic runCheck(input string tag, input logic s, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] expProd);
    issue(s, x, y);
    checkEq({tag, "_busy"}, 64'(busy), 64'd1);
    waitDone(tag, expProd, refLat(s, y), 0);
    @(posedge clk);
    #1;
    checkEq({tag, "_pulse"}, 64'(done), 64'd0);
    checkEq({tag, "_idle"}, 64'(busy), 64'd0);
    checkEq({tag, "_hold"}, prod, expProd);
  endtask

  initial begin
    logic        s;
    logic [31:0] x;
    logic [31:0] y;

    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    checkEq("rst_prod", prod, 64'd0);
    checkEq("rst_busy", 64'(busy), 64'd0);
    checkEq("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    runCheck("u3x5",      1'b0, 32'd3,        32'd5,        64'h0000_0000_0000_000F);
    runCheck("umax",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    runCheck("sminsq",    1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    runCheck("sneg3x7",   1'b1, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB);
    runCheck("uneg3x7",   1'b0, 32'hFFFF_FFFD, 32'd7,        64'h0000_0006_FFFF_FFEB);
    runCheck("bzero",     1'b0, 32'h1234_5678, 32'd0,        64'd0);
    runCheck("bmsb_u",    1'b0, 32'd1,        32'h8000_0000, 64'h0000_0000_8000_0000);
    runCheck("bmsb_s",    1'b1, 32'd1,        32'h8000_0000, 64'hFFFF_FFFF_8000_0000);

    // Start while busy is ignored; start in the done cycle is taken back-to-back.
    issue(1'b0, 32'd2, 32'd2);
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("b2b_first", 64'd4, refLat(1'b0, 32'd2), 1);
    checkEq("b2b_done_seen", 64'(done), 64'd1);
    issue(1'b0, 32'd6, 32'd7);
    checkEq("b2b_accept_busy", 64'(busy), 64'd1);
    checkEq("b2b_accept_done", 64'(done), 64'd0);
    checkEq("b2b_accept_hold", prod, 64'd4);
    waitDone("b2b_second", 64'd42, refLat(1'b0, 32'd7), 0);
    @(posedge clk);
    #1;
    checkEq("b2b_end_idle", 64'(busy), 64'd0);

    // Reset ten cycles into a long operation; start held through reset.
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkEq("abort_prod", prod, 64'd0);
    checkEq("abort_busy", 64'(busy), 64'd0);
    checkEq("abort_done", 64'(done), 64'd0);
    signed_op = 1'b0;
    a         = 32'd4;
    b         = 32'd4;
    start     = 1'b1;
    @(posedge clk);
    #1;
    checkEq("abort_in_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkEq("post_rst_busy", 64'(busy), 64'd1);
    waitDone("post_rst", 64'd16, refLat(1'b0, 32'd4), 0);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if (i % 10 == 3) y = 32'd0;
      runCheck("rand", s, x, y, refProd(s, x, y));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
